// File: rtl/ad9767_sine_dds.sv
`default_nettype none
// ============================================================================
// Module      : ad9767_sine_dds
// Description : Quarter-wave-table DDS sine source for one AD9767 channel,
//               producing 14-bit samples plus a DAC clock at f(i_clk)/2.
//               Define AD9767_SINE_TWOS_COMP_EN for two's-complement output.
// Revision    : 1.0 - initial release
// ============================================================================
module ad9767_sine_dds #(
    parameter int PHASE_W = 24,
    parameter int DATA_W  = 14
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_sine_f,
    output logic              o_dac_clk,
    output logic [DATA_W-1:0] o_dac_data
);

    localparam logic [DATA_W-1:0]  c_mid    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [127:0] c_pi_q60 = 128'sh3243F6A8885A308D;

    // round(8191.5 * sin((2i+1)*pi/1024)) from a Q60 Taylor series, folded
    // to a constant at elaboration so no real arithmetic reaches hardware.
    function automatic int sine_entry(input int idx);
        logic signed [127:0] x;
        logic signed [127:0] x2;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        x    = ($signed(128'(2 * idx + 1)) * c_pi_q60) >>> 10;
        x2   = (x * x) >>> 60;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 60) / $signed(128'(2 * k * (2 * k + 1)));
            sum  = sum + term;
        end
        return int'((sum * 16383 + (128'sd1 <<< 60)) >>> 61);
    endfunction

    logic [DATA_W-2:0] w_q_table [256];

    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_table
            localparam logic [DATA_W-2:0] c_q = (DATA_W-1)'(sine_entry(gi));
            assign w_q_table[gi] = c_q;
        end
    endgenerate

    logic              r_dac_clk;
    logic [PHASE_W-1:0] r_acc;
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_dac_data;
    logic [PHASE_W-1:0] w_ftw;
    logic [9:0]        w_p;
    logic [DATA_W-2:0] w_q;
    logic [DATA_W-1:0] w_lookup;
    logic [DATA_W-1:0] w_format;

    assign w_ftw = PHASE_W'({i_sine_f, {(PHASE_W-16){1'b0}}});
    assign w_p   = r_acc[PHASE_W-1 -: 10];

    // Odd quadrants walk the table backwards; upper half mirrors below midscale.
    always_comb begin
        w_q = w_p[8] ? w_q_table[~w_p[7:0]] : w_q_table[w_p[7:0]];
        if (w_p[9]) begin
            w_lookup = c_mid - DATA_W'(1) - {1'b0, w_q};
        end else begin
            w_lookup = c_mid + {1'b0, w_q};
        end
    end

`ifdef AD9767_SINE_TWOS_COMP_EN
    localparam logic [DATA_W-1:0] c_out_rst = '0;
    assign w_format = {~r_s1[DATA_W-1], r_s1[DATA_W-2:0]};
`else
    localparam logic [DATA_W-1:0] c_out_rst = c_mid;
    assign w_format = r_s1;
`endif

    // The strobe is the cycle with r_dac_clk high, so data moves on its fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dac_clk  <= 1'b0;
            r_acc      <= '0;
            r_s1       <= c_mid;
            r_dac_data <= c_out_rst;
        end else begin
            r_dac_clk <= ~r_dac_clk;
            if (r_dac_clk) begin
                r_acc      <= r_acc + w_ftw;
                r_s1       <= w_lookup;
                r_dac_data <= w_format;
            end
        end
    end

    assign o_dac_clk  = r_dac_clk;
    assign o_dac_data = r_dac_data;

endmodule
`default_nettype wire

// File: tb/tb_ad9767_sine_dds.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad9767_sine_dds
// Description : Self-checking bench for ad9767_sine_dds against a sine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad9767_sine_dds;

    localparam int PHASE_W = 24;
    localparam int DATA_W  = 14;
    localparam int MID     = 8192;
`ifdef AD9767_SINE_TWOS_COMP_EN
    localparam int FLIP = 'h2000;
`else
    localparam int FLIP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sine_f = 8'd0;
    logic        dac_clk;
    logic [13:0] dac_data;

    always #5 clk = ~clk;

    ad9767_sine_dds #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sine_f   (sine_f),
        .o_dac_clk  (dac_clk),
        .o_dac_data (dac_data)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    int               qref [256];
    bit               m_dclk;
    longint unsigned  m_acc;
    int               m_ph [$];
    int               m_exp;
    bit               track = 1'b0;
    int               hit_max = 0;
    int               hit_min = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sample_of(input int p);
        int quad = p >> 8;
        int i    = p & 255;
        case (quad)
            0:       return 8192 + qref[i];
            1:       return 8192 + qref[255 - i];
            2:       return 8191 - qref[i];
            default: return 8191 - qref[255 - i];
        endcase
    endfunction

    task automatic model_reset();
        m_dclk = 1'b0;
        m_acc  = 0;
        m_ph.delete();
        m_exp  = MID ^ FLIP;
    endtask

    // Output after a strobe shows the phase held two strobes earlier.
    task automatic model_strobe(input int f);
        m_ph.push_back(int'(m_acc >> (PHASE_W - 10)));
        m_acc = (m_acc + (longint'(f) << (PHASE_W - 16))) % (64'd1 << PHASE_W);
        if (m_ph.size() >= 2) m_exp = sample_of(m_ph[m_ph.size() - 2]) ^ FLIP;
        if (m_ph.size() > 2) void'(m_ph.pop_front());
    endtask

    task automatic step(input string tag);
        bit was = m_dclk;
        int f   = int'(sine_f);
        bit r   = rst;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (was) model_strobe(f);
            m_dclk = !was;
        end
        check_eq({tag, ".clk"}, 32'(dac_clk), 32'(m_dclk));
        check_eq({tag, ".data"}, 32'(dac_data), 32'(m_exp));
        if (track && was && !r) begin
            if (int'(dac_data) == (16383 ^ FLIP)) hit_max++;
            if (int'(dac_data) == (0 ^ FLIP)) hit_min++;
        end
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    initial begin
        real pi = 3.14159265358979323846;
        for (int i = 0; i < 256; i++) begin
            qref[i] = int'(8191.5 * $sin((2.0 * i + 1.0) * pi / 1024.0));
        end
        model_reset();

        rst = 1'b1; sine_f = 8'd0;
        run(4, "reset");
        rst = 1'b0;
        run(60, "f0");

        rst = 1'b1;
        step("reset2");
        rst = 1'b0; sine_f = 8'd64;
        track = 1'b1;
        run(2048 + 8, "f64");
        track = 1'b0;
        check_eq("f64.peak_seen", 32'(hit_max > 0), 32'd1);
        check_eq("f64.trough_seen", 32'(hit_min > 0), 32'd1);

        sine_f = 8'd128;
        run(1100, "f128");

        sine_f = 8'd200;
        run(301, "f200");
        rst = 1'b1;
        step("rst_pulse");
        check_eq("rst_pulse.dac_clk_low", 32'(dac_clk), 32'd0);
        check_eq("rst_pulse.midscale", 32'(dac_data), 32'(MID ^ FLIP));
        rst = 1'b0;
        run(200, "post_rst");

        for (int c = 0; c < 300; c++) begin
            sine_f = c[7:0];
            run(30, "sweep");
        end

        repeat (60) begin
            sine_f = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                step("rnd_rst");
                rst = 1'b0;
            end
            run(int'($urandom_range(1, 200)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
